// File: rtl/sgpu_axi_wchal.sv
// SGPU AXI4 write-channel master: packs 32-bit pixels into 64-bit beats and writes whole frames as 64-beat INCR bursts.
// Optional write-response error tracking is enabled by defining SGPU_WCHAL_BRESP_CHK_EN.
module sgpu_axi_wchal #(
  parameter int unsigned SCR_W      = 800,
  parameter int unsigned SCR_H      = 600,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        openChal,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  output logic        frame_done,
  output logic        err,
  output logic        o_axi_awvalid,
  input  logic        o_axi_awready,
  output logic [31:0] o_axi_awaddr,
  output logic [3:0]  o_axi_awcache,
  output logic [2:0]  o_axi_awprot,
  output logic        o_axi_awlock,
  output logic [1:0]  o_axi_awburst,
  output logic [7:0]  o_axi_awlen,
  output logic [2:0]  o_axi_awsize,
  output logic        o_axi_wvalid,
  input  logic        o_axi_wready,
  output logic [63:0] o_axi_wdata,
  output logic [7:0]  o_axi_wstrb,
  output logic        o_axi_wlast,
  input  logic        o_axi_bvalid,
  output logic        o_axi_bready,
  input  logic [1:0]  o_axi_bresp
);

  localparam int unsigned BURSTS = (SCR_W * SCR_H) / 128;
  localparam int BCW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]    BURST_WRDS = (AW + 1)'(64);
  localparam logic [BCW-1:0] LAST_BURST = BCW'(BURSTS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_AW    = 3'd1;
  localparam logic [2:0] ST_W     = 3'd2;
  localparam logic [2:0] ST_B     = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  logic [2:0]     state;
  logic [2:0]     nxt_state;
  logic           half;
  logic [31:0]    pix_lo;
  logic [63:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    fifo_cnt;
  logic [5:0]     beat_cnt;
  logic [BCW-1:0] burst_cnt;
  logic           pix_fire;
  logic           push;
  logic           pop;
  logic           b_fire;

  // Gating with rst makes pix_ready drop the moment reset asserts, not at the next edge.
  assign pix_ready = rst & openChal & (fifo_cnt < DEPTH_C) & (state != ST_FLUSH);
  assign pix_fire  = pix_valid & pix_ready;
  assign push      = pix_fire & half;
  assign pop       = o_axi_wvalid & o_axi_wready;
  assign b_fire    = o_axi_bvalid & o_axi_bready;

  assign o_axi_awvalid = (state == ST_AW);
  assign o_axi_wvalid  = (state == ST_W);
  assign o_axi_bready  = (state == ST_B);
  assign o_axi_wlast   = (state == ST_W) & (beat_cnt == 6'd63);
  assign o_axi_wdata   = mem[rd_ptr];
  assign o_axi_awcache = 4'd0;
  assign o_axi_awprot  = 3'd0;
  assign o_axi_awlock  = 1'b0;
  assign o_axi_awburst = 2'b01;
  assign o_axi_awlen   = 8'd63;
  assign o_axi_awsize  = 3'b011;
  assign o_axi_wstrb   = 8'hFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      half   <= 1'b0;
      pix_lo <= 32'd0;
    end else if (state == ST_FLUSH) begin
      half <= 1'b0;
    end else if (pix_fire) begin
      if (!half) pix_lo <= pix_data;
      half <= ~half;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_data, pix_lo};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // A burst, once its address is offered, always runs to its B response before a flush.
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: begin
        if (!openChal)                   nxt_state = ST_FLUSH;
        else if (fifo_cnt >= BURST_WRDS) nxt_state = ST_AW;
      end
      ST_AW:    if (o_axi_awready) nxt_state = ST_W;
      ST_W:     if (pop && beat_cnt == 6'd63) nxt_state = ST_B;
      ST_B:     if (o_axi_bvalid) nxt_state = openChal ? ST_IDLE : ST_FLUSH;
      ST_FLUSH: nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt     <= 6'd0;
      burst_cnt    <= '0;
      o_axi_awaddr <= BASE_ADDR;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_AW: if (o_axi_awready) beat_cnt <= 6'd0;
        ST_W:  if (pop) beat_cnt <= beat_cnt + 6'd1;
        ST_B: begin
          if (o_axi_bvalid) begin
            if (burst_cnt == LAST_BURST) begin
              burst_cnt    <= '0;
              o_axi_awaddr <= BASE_ADDR;
              frame_done   <= 1'b1;
            end else begin
              burst_cnt    <= burst_cnt + BCW'(1);
              o_axi_awaddr <= o_axi_awaddr + 32'd512;
            end
          end
        end
        ST_FLUSH: begin
          burst_cnt    <= '0;
          o_axi_awaddr <= BASE_ADDR;
        end
        default: ;
      endcase
    end
  end

`ifdef SGPU_WCHAL_BRESP_CHK_EN
  // Sticky until reset or a channel flush so software can poll it after a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                err <= 1'b0;
    else if (state == ST_FLUSH)              err <= 1'b0;
    else if (b_fire && o_axi_bresp != 2'b00) err <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^{o_axi_bresp, b_fire};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sgpu_axi_wchal.sv
// Self-checking bench for sgpu_axi_wchal with a 16x16 frame (two bursts per frame).
module tb_sgpu_axi_wchal;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic openChal = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_ready;
  logic [31:0] pix_data = 32'd0;
  logic frame_done, err;
  logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr;
  logic [3:0] awcache;
  logic [2:0] awprot, awsize;
  logic [1:0] awburst, bresp;
  logic [7:0] awlen, wstrb;
  logic [63:0] wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic wl_q[$];
  int b_cnt = 0;
  int fd_cnt = 0;
  int fd_wide = 0;
  int stab_viol = 0;
  logic fd_prev = 1'b0, aw_stall = 1'b0, w_stall = 1'b0;
  logic [31:0] aw_prev = '0;
  logic [63:0] wd_prev = '0;
  logic rand_mode = 1'b0;
  logic aw_hold = 1'b0;
  int bad_b_idx = -1;

  sgpu_axi_wchal #(.SCR_W(16), .SCR_H(16), .BASE_ADDR(BASE), .FIFO_DEPTH(128)) dut (
    .clk(clk), .rst(rst), .openChal(openChal),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .frame_done(frame_done), .err(err),
    .o_axi_awvalid(awvalid), .o_axi_awready(awready), .o_axi_awaddr(awaddr),
    .o_axi_awcache(awcache), .o_axi_awprot(awprot), .o_axi_awlock(awlock),
    .o_axi_awburst(awburst), .o_axi_awlen(awlen), .o_axi_awsize(awsize),
    .o_axi_wvalid(wvalid), .o_axi_wready(wready), .o_axi_wdata(wdata),
    .o_axi_wstrb(wstrb), .o_axi_wlast(wlast),
    .o_axi_bvalid(bvalid), .o_axi_bready(bready), .o_axi_bresp(bresp)
  );

  initial forever #5 clk = ~clk;

  // AXI slave: responds just after each rising edge, either fully ready or randomly stalling.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rand_mode) begin
        awready = ($urandom_range(0, 1) == 1);
        wready  = ($urandom_range(0, 3) != 0);
        bvalid  = ($urandom_range(0, 1) == 1);
      end else begin
        awready = !aw_hold;
        wready  = 1'b1;
        bvalid  = 1'b1;
      end
      bresp = (b_cnt == bad_b_idx) ? 2'b10 : 2'b00;
    end
  end

  // Monitor: samples on the falling edge the handshakes that complete at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      aw_stall = 1'b0; w_stall = 1'b0; fd_prev = 1'b0;
    end else begin
      if (aw_stall && (!awvalid || awaddr !== aw_prev)) stab_viol++;
      if (w_stall && (!wvalid || wdata !== wd_prev)) stab_viol++;
      aw_stall = awvalid && !awready; aw_prev = awaddr;
      w_stall  = wvalid && !wready;   wd_prev = wdata;
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (wvalid && wready) begin wd_q.push_back(wdata); wl_q.push_back(wlast); end
      if (bvalid && bready) b_cnt++;
      if (frame_done) begin fd_cnt++; if (fd_prev) fd_wide++; end
      fd_prev = frame_done;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] exp_beat(input int base, input int k);
    logic [31:0] lo, hi;
    lo = 32'(base + 2 * k);
    hi = 32'(base + 2 * k + 1);
    return {hi, lo};
  endfunction

  function automatic logic [31:0] get_aw(input int i);
    if (i < aw_q.size()) return aw_q[i];
    return 'x;
  endfunction

  function automatic logic [63:0] get_wd(input int i);
    if (i < wd_q.size()) return wd_q[i];
    return 'x;
  endfunction

  function automatic logic get_wl(input int i);
    if (i < wl_q.size()) return wl_q[i];
    return 1'bx;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b0; openChal = 1'b0; pix_valid = 1'b0;
    rand_mode = 1'b0; aw_hold = 1'b0; bad_b_idx = -1;
    cycles(3);
    aw_q.delete(); wd_q.delete(); wl_q.delete();
    b_cnt = 0; fd_cnt = 0; fd_wide = 0; stab_viol = 0;
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      bit acc;
      k = 0; acc = 1'b0;
      pix_valid = 1'b1; pix_data = 32'(base + i);
      while (!acc && k < 2000) begin
        @(negedge clk); acc = pix_ready;
        @(posedge clk); #1; k++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("[TB] FAIL feed_timeout: pixel %0d not accepted, pix_ready=%b expected 1", i, pix_ready);
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_b(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (b_cnt < n && k < budget) begin @(posedge clk); #1; k++; end
    checks++;
    if (b_cnt < n) begin
      errors++;
      $display("[TB] FAIL %s: B responses got %0d expected %0d", name, b_cnt, n);
    end
  endtask

  task automatic wait_w(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (wd_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    checks++;
    if (wd_q.size() < n) begin
      errors++;
      $display("[TB] FAIL %s: W beats got %0d expected %0d", name, wd_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; openChal = 1'b1;
    #12;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_awvalid: got %b expected 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wvalid: got %b expected 0", wvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("[TB] FAIL rst_bready: got %b expected 0", bready); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b expected 0", frame_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", err); end
    checks++; if (awaddr !== BASE) begin errors++; $display("[TB] FAIL rst_awaddr: got %h expected %h", awaddr, BASE); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_ready: got %b expected 0", pix_ready); end
    @(posedge clk); #1;
    rst = 1'b1; openChal = 1'b0;
    cycles(1);
    checks++; if (awburst !== 2'b01) begin errors++; $display("[TB] FAIL awburst: got %b expected 01", awburst); end
    checks++; if (awlen !== 8'd63) begin errors++; $display("[TB] FAIL awlen: got %0d expected 63", awlen); end
    checks++; if (awsize !== 3'b011) begin errors++; $display("[TB] FAIL awsize: got %b expected 011", awsize); end
    checks++; if ({awcache, awprot, awlock} !== 8'd0) begin errors++; $display("[TB] FAIL aw_attr: got %h expected 0", {awcache, awprot, awlock}); end
    checks++; if (wstrb !== 8'hFF) begin errors++; $display("[TB] FAIL wstrb: got %h expected ff", wstrb); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL closed_pix_ready: got %b expected 0", pix_ready); end
    openChal = 1'b1;
    cycles(2);
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL open_pix_ready: got %b expected 1", pix_ready); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("[TB] FAIL empty_awvalid: got %b expected 0", awvalid); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    openChal = 1'b1;
    feed(0, 128);
    wait_w(20, 500, "mid_burst_wait");
    #2;
    rst = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b0) begin errors++; $display("[TB] FAIL async_wvalid: got %b expected 0", wvalid); end
    checks++; if (awaddr !== BASE) begin errors++; $display("[TB] FAIL async_awaddr: got %h expected %h", awaddr, BASE); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_pix_ready: got %b expected 0", pix_ready); end
    checks++; if (awvalid !== 1'b0) begin errors++; $display("[TB] FAIL async_awvalid: got %b expected 0", awvalid); end
    @(posedge clk); #1;
    rst = 1'b1;
    aw_q.delete();
    cycles(10);
    checks++; if (aw_q.size() !== 0) begin errors++; $display("[TB] FAIL post_reset_aw: got %0d bursts expected 0", aw_q.size()); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_pix_ready: got %b expected 1", pix_ready); end
  endtask

  task automatic test_single_burst();
    do_reset();
    openChal = 1'b1;
    feed(0, 128);
    wait_b(1, 500, "single_b");
    cycles(3);
    checks++; if (aw_q.size() !== 1) begin errors++; $display("[TB] FAIL single_aw_count: got %0d expected 1", aw_q.size()); end
    checks++; if (get_aw(0) !== BASE) begin errors++; $display("[TB] FAIL single_aw_addr: got %h expected %h", get_aw(0), BASE); end
    checks++; if (get_wd(0) !== 64'h00000001_00000000) begin errors++; $display("[TB] FAIL beat0_data: got %h expected 0000000100000000", get_wd(0)); end
    checks++; if (wd_q.size() !== 64) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 64", wd_q.size()); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (get_wd(i) !== exp_beat(0, i) || get_wl(i) !== (i == 63)) begin
        errors++;
        $display("[TB] FAIL single_beat%0d: got %h last=%b expected %h last=%b", i, get_wd(i), get_wl(i), exp_beat(0, i), (i == 63));
      end
    end
    checks++; if (awaddr !== BASE + 32'd512) begin errors++; $display("[TB] FAIL next_awaddr: got %h expected %h", awaddr, BASE + 32'd512); end
    checks++; if (fd_cnt !== 0) begin errors++; $display("[TB] FAIL single_frame_done: got %0d expected 0", fd_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [4];
    exp_a = '{BASE, BASE + 32'd512, BASE, BASE + 32'd512};
    do_reset();
    openChal = 1'b1;
    feed(1000, 512);
    wait_b(4, 3000, "frames_b");
    cycles(3);
    checks++; if (aw_q.size() !== 4) begin errors++; $display("[TB] FAIL frames_aw_count: got %0d expected 4", aw_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_aw(i) !== exp_a[i]) begin errors++; $display("[TB] FAIL frames_aw%0d: got %h expected %h", i, get_aw(i), exp_a[i]); end
    end
    checks++; if (fd_cnt !== 2) begin errors++; $display("[TB] FAIL frames_done_count: got %0d expected 2", fd_cnt); end
    checks++; if (fd_wide !== 0) begin errors++; $display("[TB] FAIL frames_done_width: got %0d wide pulses expected 0", fd_wide); end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (get_wd(i) !== exp_beat(1000, i) || get_wl(i) !== (i % 64 == 63)) begin
        errors++;
        $display("[TB] FAIL frames_beat%0d: got %h last=%b expected %h last=%b", i, get_wd(i), get_wl(i), exp_beat(1000, i), (i % 64 == 63));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [3];
    exp_a = '{BASE, BASE + 32'd512, BASE};
    do_reset();
    rand_mode = 1'b1;
    openChal = 1'b1;
    feed(2000, 384);
    wait_b(3, 6000, "bp_b");
    cycles(3);
    rand_mode = 1'b0;
    checks++; if (aw_q.size() !== 3) begin errors++; $display("[TB] FAIL bp_aw_count: got %0d expected 3", aw_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_aw(i) !== exp_a[i]) begin errors++; $display("[TB] FAIL bp_aw%0d: got %h expected %h", i, get_aw(i), exp_a[i]); end
    end
    checks++; if (fd_cnt !== 1) begin errors++; $display("[TB] FAIL bp_frame_done: got %0d expected 1", fd_cnt); end
    checks++; if (stab_viol !== 0) begin errors++; $display("[TB] FAIL bp_stability: got %0d violations expected 0", stab_viol); end
    for (int i = 0; i < 192; i++) begin
      checks++;
      if (get_wd(i) !== exp_beat(2000, i) || get_wl(i) !== (i % 64 == 63)) begin
        errors++;
        $display("[TB] FAIL bp_beat%0d: got %h last=%b expected %h last=%b", i, get_wd(i), get_wl(i), exp_beat(2000, i), (i % 64 == 63));
      end
    end
  endtask

  task automatic test_close_channel();
    int lasts;
    do_reset();
    aw_hold = 1'b1;
    openChal = 1'b1;
    feed(3000, 200);
    aw_hold = 1'b0;
    wait_w(10, 500, "close_wait");
    openChal = 1'b0;
    wait_b(1, 500, "close_b");
    cycles(5);
    lasts = 0;
    for (int i = 0; i < wl_q.size(); i++) if (wl_q[i] === 1'b1) lasts++;
    checks++; if (wd_q.size() !== 64) begin errors++; $display("[TB] FAIL close_beats: got %0d expected 64", wd_q.size()); end
    checks++; if (get_wl(63) !== 1'b1 || lasts !== 1) begin errors++; $display("[TB] FAIL close_wlast: got last63=%b count=%0d expected 1 and 1", get_wl(63), lasts); end
    checks++; if (get_wd(63) !== exp_beat(3000, 63)) begin errors++; $display("[TB] FAIL close_beat63: got %h expected %h", get_wd(63), exp_beat(3000, 63)); end
    checks++; if (aw_q.size() !== 1) begin errors++; $display("[TB] FAIL close_aw_count: got %0d expected 1", aw_q.size()); end
    checks++; if (pix_ready !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("[TB] FAIL closed_idle: got pix_ready=%b awvalid=%b expected 0 0", pix_ready, awvalid); end
    openChal = 1'b1;
    feed(4000, 128);
    wait_b(2, 500, "reopen_b");
    cycles(3);
    checks++; if (get_aw(1) !== BASE) begin errors++; $display("[TB] FAIL reopen_awaddr: got %h expected %h", get_aw(1), BASE); end
    checks++; if (get_wd(64) !== exp_beat(4000, 0)) begin errors++; $display("[TB] FAIL reopen_beat0: got %h expected %h", get_wd(64), exp_beat(4000, 0)); end
    checks++; if (wd_q.size() !== 128) begin errors++; $display("[TB] FAIL reopen_beats: got %0d expected 128", wd_q.size()); end
  endtask

  task automatic test_bresp_err();
    logic exp_err;
`ifdef SGPU_WCHAL_BRESP_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    bad_b_idx = 1;
    openChal = 1'b1;
    feed(6000, 128);
    wait_b(1, 500, "err_b1");
    cycles(2);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_after_okay: got %b expected 0", err); end
    feed(6128, 128);
    wait_b(2, 500, "err_b2");
    cycles(2);
    checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL err_after_slverr: got %b expected %b", err, exp_err); end
    feed(6256, 128);
    wait_b(3, 500, "err_b3");
    cycles(2);
    checks++; if (err !== exp_err) begin errors++; $display("[TB] FAIL err_sticky: got %b expected %b", err, exp_err); end
    openChal = 1'b0;
    cycles(3);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_flush_clear: got %b expected 0", err); end
    bad_b_idx = -1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_single_burst();
    test_back_to_back();
    test_backpressure();
    test_close_channel();
    test_bresp_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
